pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Registered program-counter generator for the rvseed core, replacing the purely combinational next-PC mux.
- Holds the fetch PC and issues fetch requests over a valid/ready handshake.
- Evaluates all RV32I branch conditions from execute-stage flags, and applies redirects in priority order: trap, mret, jalr, jal, taken branch.
- Keeps a redirect that arrives during a stalled fetch pending, and supports debug halt/resume.

Parameters:
- CPU_WIDTH, 32, PC/data width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- IALIGN, 4, instruction alignment in bytes. 4 checks target[1:0]; 2 checks target[0] only (C extension).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- if_valid  out  1  fetch request valid
- if_ready  in  1  instruction memory accepts request
- if_pc  out  CPU_WIDTH  fetch address
- if_kill  out  1  the beat accepted this cycle is stale; fetch stage discards it
- branch  in  1  conditional branch in EX
- br_funct3  in  3  branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU encodings)
- zero  in  1  ALU result zero (rs1==rs2)
- lt  in  1  signed rs1<rs2
- ltu  in  1  unsigned rs1<rs2
- jump  in  1  jal in EX
- jalr  in  1  jalr in EX
- ex_pc  in  CPU_WIDTH  PC of the EX instruction
- reg1_rdata  in  CPU_WIDTH  rs1 value
- imm  in  CPU_WIDTH  sign-extended immediate
- trap  in  1  trap entry request
- trap_vec  in  CPU_WIDTH  trap target (mtvec)
- mret  in  1  return from trap
- epc  in  CPU_WIDTH  mepc
- halt_req  in  1  debug halt request (level)
- resume  in  1  debug resume pulse
- halted  out  1  block is in HALT
- flush  out  1  redirect taken this cycle; kill IF/ID (combinational)
- misalign  out  1  EX redirect target misaligned (combinational)
- misalign_addr  out  CPU_WIDTH  offending target

Behaviour:
- Reset (async): pc=RESET_VEC, state=RUN, if_valid=0, if_kill=0, halted=0, pend=0. flush and misalign are 0 while rst=1. if_valid rises on the first clock edge after rst deasserts.
- Branch taken:
  - BEQ: zero. BNE: !zero.
  - BLT: lt. BGE: !lt.
  - BLTU: ltu. BGEU: !ltu.
  - funct3 010/011 are never taken.
- Targets:
  - Branch and jal: ex_pc+imm.
  - jalr: (reg1_rdata+imm) with bit0 cleared.
  - All additions are modulo 2^CPU_WIDTH; wrap-around is silent.
- Misalign: an EX redirect whose target fails the IALIGN check asserts misalign and misalign_addr. No redirect occurs and flush=0; the core raises trap afterwards. trap_vec and epc are not checked.
- Priority: trap > mret > jalr > jump > taken branch. Only the winner is applied.
- Sequential update when no redirect:
  - State RUN, if_valid and if_ready both high: pc <= pc+4.
  - Otherwise pc holds.
  - if_pc always equals pc.
- Redirect (flush=1):
  - if_valid=0, or if_valid=1 and if_ready=1: pc <= target next cycle.
  - if_valid=1 and if_ready=0: handshake rules forbid changing if_pc. Latch pend_pc=target and set pend=1, then enter state HOLD.
- HOLD:
  - if_pc stays stable until if_ready.
  - In the accept cycle if_kill=1, then pc <= pend_pc, pend cleared, state RUN.
  - A newer redirect during HOLD overwrites pend_pc, so the last one wins.
  - trap in HOLD behaves the same way.
- Halt:
  - halt_req in RUN with no outstanding unaccepted beat: if_valid=0 next cycle, state HALT, halted=1.
  - If a beat is unaccepted, HALT is entered after its acceptance.
  - In HALT, redirects still update pc (directly, since nothing is outstanding).
  - resume moves to RUN next cycle; if_valid=1 the cycle after, at the current pc.
  - resume is ignored outside HALT.
  - halt_req and resume together in HALT: resume wins for one cycle, then halt_req re-halts.
- Reset mid-HOLD or mid-HALT: immediate return to reset values; pend is discarded.

Decomposition:
- Shared rvseed_defines.v gains: CPU_WIDTH, the branch funct3 encodings, and state encodings PC_RUN/PC_HOLD/PC_HALT.
- One natural sub-module: pc_br_cond (combinational branch-condition evaluator), reusable by a future branch predictor.

Test Plan:
- Reset with RESET_VEC=32'h8000_0000, if_ready=1 -> if_pc sequence 8000_0000, 8000_0004, 8000_0008; if_valid=0 during rst.
- BNE with zero=0, ex_pc=0x100, imm=0xFFFF_FFF0 -> flush=1, next if_pc=0x0F0. BGEU with ltu=1 -> no flush.
- jalr with reg1_rdata=0x203, imm=0 -> target 0x202. With IALIGN=4: misalign=1, misalign_addr=0x202, flush=0. With IALIGN=2: if_pc=0x202.
- if_ready held 0 at if_pc=0x40, jal to 0x80, then a branch to 0xC0 a cycle later -> if_pc stays 0x40. On acceptance if_kill=1; next if_pc=0xC0.
- trap (trap_vec=0x10) and jalr in the same cycle -> pc=0x10. mret (epc=0x44) next -> pc=0x44.
- halt_req asserted -> halted=1, if_valid=0. trap during HALT -> pc=trap_vec, still halted. resume -> fetch resumes at trap_vec. pc=0xFFFF_FFFC with no redirect -> wraps to 0x0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types for the rvseed fetch PC generator.
// Branch funct3 codes, PC FSM states, alignment helper.
package pc_gen_pkg;

  localparam int RV_CPU_WIDTH = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    PC_RUN  = 2'd0,
    PC_HOLD = 2'd1,
    PC_HALT = 2'd2
  } pc_state_t;

  // ialign 2 only needs halfword alignment (C extension)
  function automatic logic misaligned(
    input logic [1:0] lo,
    input int         ialign
  );
    if (ialign == 2) return lo[0];
    return |lo;
  endfunction

endpackage

// File: rtl/pc_br_cond.sv
// RV32I branch-condition evaluator.
// Pure combinational; reusable by a branch predictor.
module pc_br_cond
  import pc_gen_pkg::*;
(
  input  logic       branch,
  input  logic [2:0] br_funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken
);

  // decode funct3 into a taken decision; 010/011 never take
  always_comb begin
    taken = 1'b0;
    if (branch) begin
      unique case (br_funct3)
        F3_BEQ:  taken = zero;
        F3_BNE:  taken = !zero;
        F3_BLT:  taken = lt;
        F3_BGE:  taken = !lt;
        F3_BLTU: taken = ltu;
        F3_BGEU: taken = !ltu;
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Registered fetch PC generator with redirect priority,
// stalled-redirect pending and debug halt/resume.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                   CPU_WIDTH = RV_CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_VEC = '0,
  parameter int                   IALIGN    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [CPU_WIDTH-1:0] if_pc,
  output logic                 if_kill,
  input  logic                 branch,
  input  logic [2:0]           br_funct3,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 jump,
  input  logic                 jalr,
  input  logic [CPU_WIDTH-1:0] ex_pc,
  input  logic [CPU_WIDTH-1:0] reg1_rdata,
  input  logic [CPU_WIDTH-1:0] imm,
  input  logic                 trap,
  input  logic [CPU_WIDTH-1:0] trap_vec,
  input  logic                 mret,
  input  logic [CPU_WIDTH-1:0] epc,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic                 halted,
  output logic                 flush,
  output logic                 misalign,
  output logic [CPU_WIDTH-1:0] misalign_addr
);

  pc_state_t            state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic [CPU_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                 pend_q, pend_d;
  logic                 valid_q, valid_d;

  logic                 br_taken;
  logic [CPU_WIDTH-1:0] add_pc;
  logic [CPU_WIDTH-1:0] add_rs;
  logic [CPU_WIDTH-1:0] ex_tgt;
  logic [CPU_WIDTH-1:0] tgt;
  logic                 ex_redir;
  logic                 ex_bad;
  logic                 sys_redir;
  logic                 stall;
  logic                 accept;

  pc_br_cond u_br_cond (
    .branch    (branch),
    .br_funct3 (br_funct3),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu),
    .taken     (br_taken)
  );

  assign add_pc = ex_pc + imm;
  assign add_rs = reg1_rdata + imm;

  assign if_valid = valid_q;
  assign if_pc    = pc_q;
  assign halted   = (state_q == PC_HALT);

  assign stall  = valid_q && !if_ready;
  assign accept = valid_q && if_ready;

  // EX target select and alignment check (jalr beats jal/branch)
  always_comb begin
    ex_redir = jalr || jump || br_taken;
    ex_tgt   = add_pc;
    if (jalr) ex_tgt = {add_rs[CPU_WIDTH-1:1], 1'b0};
    ex_bad   = ex_redir && misaligned(ex_tgt[1:0], IALIGN);
  end

  // redirect arbitration: trap > mret > EX; trap/mret unchecked
  always_comb begin
    sys_redir     = trap || mret;
    flush         = !rst && (sys_redir || (ex_redir && !ex_bad));
    misalign      = !rst && !sys_redir && ex_bad;
    misalign_addr = ex_tgt;
    if (trap)      tgt = trap_vec;
    else if (mret) tgt = epc;
    else           tgt = ex_tgt;
  end

  // next-state, next-pc and kill decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pend_d    = pend_q;
    valid_d   = valid_q;
    if_kill   = 1'b0;
    unique case (state_q)
      PC_RUN: begin
        valid_d = 1'b1;
        if (flush && stall) begin
          // if_pc must stay put until the beat is taken
          pend_pc_d = tgt;
          pend_d    = 1'b1;
          state_d   = PC_HOLD;
        end else begin
          if (flush)       pc_d = tgt;
          else if (accept) pc_d = pc_q + CPU_WIDTH'(4);
          if (halt_req && !stall) begin
            state_d = PC_HALT;
            valid_d = 1'b0;
          end
        end
      end
      PC_HOLD: begin
        valid_d = 1'b1;
        if (flush) pend_pc_d = tgt;
        if (if_ready) begin
          // stale beat leaves now; newest redirect wins
          if_kill = 1'b1;
          pc_d    = flush ? tgt : pend_pc_q;
          pend_d  = 1'b0;
          state_d = PC_RUN;
        end
      end
      PC_HALT: begin
        valid_d = 1'b0;
        if (flush)  pc_d    = tgt;
        if (resume) state_d = PC_RUN;
      end
      default: begin
        state_d = PC_RUN;
        valid_d = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // state registers, async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PC_RUN;
      pc_q      <= RESET_VEC;
      pend_pc_q <= RESET_VEC;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen.
// Two instances: IALIGN=4 (a) and IALIGN=2 (b).
module tb_pc_gen;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready;
  logic        branch;
  logic [2:0]  br_funct3;
  logic        zero, lt, ltu;
  logic        jump, jalr;
  logic [31:0] ex_pc, reg1_rdata, imm;
  logic        trap, mret;
  logic [31:0] trap_vec, epc;
  logic        halt_req, resume;

  logic        a_valid, a_kill, a_halted, a_flush, a_mis;
  logic [31:0] a_pc, a_mis_addr;
  logic        b_valid, b_kill, b_halted, b_flush, b_mis;
  logic [31:0] b_pc, b_mis_addr;

  always #5 clk = ~clk;

  pc_gen #(
    .CPU_WIDTH (32),
    .RESET_VEC (32'h8000_0000),
    .IALIGN    (4)
  ) dut_a (
    .clk (clk), .rst (rst),
    .if_valid (a_valid), .if_ready (if_ready),
    .if_pc (a_pc), .if_kill (a_kill),
    .branch (branch), .br_funct3 (br_funct3),
    .zero (zero), .lt (lt), .ltu (ltu),
    .jump (jump), .jalr (jalr),
    .ex_pc (ex_pc), .reg1_rdata (reg1_rdata), .imm (imm),
    .trap (trap), .trap_vec (trap_vec),
    .mret (mret), .epc (epc),
    .halt_req (halt_req), .resume (resume),
    .halted (a_halted), .flush (a_flush),
    .misalign (a_mis), .misalign_addr (a_mis_addr)
  );

  pc_gen #(
    .CPU_WIDTH (32),
    .RESET_VEC (32'h8000_0000),
    .IALIGN    (2)
  ) dut_b (
    .clk (clk), .rst (rst),
    .if_valid (b_valid), .if_ready (if_ready),
    .if_pc (b_pc), .if_kill (b_kill),
    .branch (branch), .br_funct3 (br_funct3),
    .zero (zero), .lt (lt), .ltu (ltu),
    .jump (jump), .jalr (jalr),
    .ex_pc (ex_pc), .reg1_rdata (reg1_rdata), .imm (imm),
    .trap (trap), .trap_vec (trap_vec),
    .mret (mret), .epc (epc),
    .halt_req (halt_req), .resume (resume),
    .halted (b_halted), .flush (b_flush),
    .misalign (b_mis), .misalign_addr (b_mis_addr)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty observed=%h required=entry", obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch = 1'b0; br_funct3 = 3'b000;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    jump = 1'b0; jalr = 1'b0;
    trap = 1'b0; mret = 1'b0;
    resume = 1'b0;
    ex_pc = '0; reg1_rdata = '0; imm = '0;
  endtask

  initial begin
    idle();
    halt_req = 1'b0;
    trap_vec = '0;
    epc = '0;
    if_ready = 1'b1;
    rst = 1'b1;
    trap = 1'b1;
    trap_vec = 32'h10;
    tick(); tick();

    // reset state; flush gated by rst even with trap high
    push("rst_valid", 0);           pop_chk(32'(a_valid));
    push("rst_pc", 32'h8000_0000);  pop_chk(a_pc);
    push("rst_halted", 0);          pop_chk(32'(a_halted));
    push("rst_flush", 0);           pop_chk(32'(a_flush));
    push("rst_kill", 0);            pop_chk(32'(a_kill));
    push("rst_valid_b", 0);         pop_chk(32'(b_valid));

    trap = 1'b0;
    rst = 1'b0;
    push("first_valid", 1);
    push("first_pc", 32'h8000_0000);
    tick();
    pop_chk(32'(a_valid));
    pop_chk(a_pc);
    push("seq_pc1", 32'h8000_0004);
    tick(); pop_chk(a_pc);
    push("seq_pc2", 32'h8000_0008);
    tick(); pop_chk(a_pc);

    // BNE taken backwards
    branch = 1'b1; br_funct3 = 3'b001; zero = 1'b0;
    ex_pc = 32'h100; imm = 32'hFFFF_FFF0;
    #1;
    push("bne_flush", 1); pop_chk(32'(a_flush));
    push("bne_pc", 32'h0F0);
    push("bne_pc_b", 32'h0F0);
    tick(); idle();
    pop_chk(a_pc); pop_chk(b_pc);

    // BGEU with ltu=1: not taken
    branch = 1'b1; br_funct3 = 3'b111; ltu = 1'b1;
    ex_pc = 32'h100; imm = 32'h40;
    #1;
    push("bgeu_flush", 0); pop_chk(32'(a_flush));
    push("bgeu_pc", 32'h0F4);
    tick(); idle(); pop_chk(a_pc);

    // funct3 010 never taken
    branch = 1'b1; br_funct3 = 3'b010; zero = 1'b1;
    ex_pc = 32'h100; imm = 32'h40;
    #1;
    push("f3_010_flush", 0); pop_chk(32'(a_flush));
    push("f3_010_pc", 32'h0F8);
    tick(); idle(); pop_chk(a_pc);

    // BLT taken forward
    branch = 1'b1; br_funct3 = 3'b100; lt = 1'b1;
    ex_pc = 32'h1000; imm = 32'h20;
    #1;
    push("blt_flush", 1); pop_chk(32'(a_flush));
    push("blt_pc", 32'h1020);
    tick(); idle(); pop_chk(a_pc);

    // jalr to 0x202: misaligned only for IALIGN=4
    jalr = 1'b1; reg1_rdata = 32'h203; imm = 32'h0;
    #1;
    push("jalr_mis_a", 1);         pop_chk(32'(a_mis));
    push("jalr_mis_addr", 32'h202); pop_chk(a_mis_addr);
    push("jalr_flush_a", 0);       pop_chk(32'(a_flush));
    push("jalr_flush_b", 1);       pop_chk(32'(b_flush));
    push("jalr_mis_b", 0);         pop_chk(32'(b_mis));
    push("jalr_pc_a", 32'h1024);
    push("jalr_pc_b", 32'h202);
    tick(); idle();
    pop_chk(a_pc); pop_chk(b_pc);

    // jal to 0x40, then stall there
    jump = 1'b1; ex_pc = 32'h0; imm = 32'h40;
    push("jal_pc", 32'h40);
    tick(); idle(); pop_chk(a_pc);
    if_ready = 1'b0;
    jump = 1'b1; ex_pc = 32'h0; imm = 32'h80;
    #1;
    push("stall_flush", 1); pop_chk(32'(a_flush));
    push("hold_pc", 32'h40);
    push("hold_valid", 1);
    tick(); idle();
    pop_chk(a_pc); pop_chk(32'(a_valid));
    branch = 1'b1; br_funct3 = 3'b000; zero = 1'b1;
    ex_pc = 32'h0; imm = 32'hC0;
    push("hold2_pc", 32'h40);
    tick(); idle(); pop_chk(a_pc);
    if_ready = 1'b1;
    #1;
    push("kill_a", 1); pop_chk(32'(a_kill));
    push("kill_b", 1); pop_chk(32'(b_kill));
    push("last_wins_pc", 32'hC0);
    push("kill_clear", 0);
    tick();
    pop_chk(a_pc); pop_chk(32'(a_kill));

    // trap beats jalr, then mret
    trap = 1'b1; trap_vec = 32'h10;
    jalr = 1'b1; reg1_rdata = 32'h300; imm = 32'h0;
    #1;
    push("trap_flush", 1); pop_chk(32'(a_flush));
    push("trap_pc", 32'h10);
    tick(); idle(); pop_chk(a_pc);
    mret = 1'b1; epc = 32'h44;
    push("mret_pc", 32'h44);
    tick(); idle(); pop_chk(a_pc);

    // halt after accepting the 0x44 beat
    halt_req = 1'b1;
    push("halt_halted", 1);
    push("halt_valid", 0);
    push("halt_pc", 32'h48);
    tick(); halt_req = 1'b0;
    pop_chk(32'(a_halted)); pop_chk(32'(a_valid)); pop_chk(a_pc);

    // trap while halted redirects pc directly
    trap = 1'b1; trap_vec = 32'h200;
    push("hlt_trap_pc", 32'h200);
    push("hlt_trap_halted", 1);
    push("hlt_trap_valid", 0);
    tick(); idle();
    pop_chk(a_pc); pop_chk(32'(a_halted)); pop_chk(32'(a_valid));

    // resume: RUN next cycle, fetch the cycle after
    resume = 1'b1;
    push("res_halted", 0);
    push("res_valid", 0);
    tick(); resume = 1'b0;
    pop_chk(32'(a_halted)); pop_chk(32'(a_valid));
    push("res_valid2", 1);
    push("res_pc", 32'h200);
    tick();
    pop_chk(32'(a_valid)); pop_chk(a_pc);
    push("res_pc2", 32'h204);
    tick(); pop_chk(a_pc);

    // halt_req with resume: one RUN cycle, then re-halt
    halt_req = 1'b1;
    tick();
    resume = 1'b1;
    push("hr_run", 0);
    tick(); resume = 1'b0;
    pop_chk(32'(a_halted));
    push("hr_rehalt", 1);
    push("hr_rehalt_b", 1);
    tick();
    pop_chk(32'(a_halted)); pop_chk(32'(b_halted));
    halt_req = 1'b0;
    resume = 1'b1;
    tick(); resume = 1'b0;
    push("hr_valid", 1);
    push("hr_pc", 32'h208);
    tick();
    pop_chk(32'(a_valid)); pop_chk(a_pc);

    // resume outside HALT is ignored
    resume = 1'b1;
    push("res_ign_halted", 0);
    push("res_ign_pc", 32'h20C);
    tick(); resume = 1'b0;
    pop_chk(32'(a_halted)); pop_chk(a_pc);

    // wrap past top of address space
    trap = 1'b1; trap_vec = 32'hFFFF_FFFC;
    push("top_pc", 32'hFFFF_FFFC);
    tick(); idle(); pop_chk(a_pc);
    push("wrap_pc", 32'h0);
    tick(); pop_chk(a_pc);

    // reset while HOLD discards the pending redirect
    if_ready = 1'b0;
    jump = 1'b1; ex_pc = 32'h0; imm = 32'h80;
    tick(); idle();
    if_ready = 1'b1;
    rst = 1'b1;
    #1;
    push("rhold_pc", 32'h8000_0000); pop_chk(a_pc);
    push("rhold_valid", 0);          pop_chk(32'(a_valid));
    push("rhold_kill", 0);           pop_chk(32'(a_kill));
    tick();
    rst = 1'b0;
    push("rhold_valid2", 1);
    push("rhold_pc2", 32'h8000_0000);
    tick();
    pop_chk(32'(a_valid)); pop_chk(a_pc);
    push("rhold_pc3", 32'h8000_0004);
    tick(); pop_chk(a_pc);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
